async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
Write-domain control stage of the asynchronous FIFO. It owns the write pointer and produces the binary RAM write address and the registered Gray write pointer exported to the read domain. It also synchronizes the read-domain Gray pointer into clk and generates registered full, almost_full and fill-level status for the producer.

Parameters:
ADDR_W, 8, address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, flop stages on rd_gray_ptr crossing (legal 2..4).
AFULL_THRESH, 2**ADDR_W-4, almost_full asserts when level >= this value (legal 1..2**ADDR_W).

Ports:
clk  input  1  write-domain clock
rst_n  input  1  async active-low reset
wr_en  input  1  producer push request
rd_gray_ptr  input  ADDR_W+1  read Gray pointer, asynchronous to clk
wr_gray_ptr  output  ADDR_W+1  registered Gray write pointer to read domain
wr_addr  output  ADDR_W  RAM write address (low bits of binary pointer)
wr_accept  output  1  combinational RAM write enable = wr_en & ~full
full  output  1  registered full flag
almost_full  output  1  registered, level >= AFULL_THRESH
wr_level  output  ADDR_W+1  registered pessimistic fill level, 0..2**ADDR_W

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): wbin, wr_gray_ptr, all sync flops, full, almost_full and wr_level clear to 0. An assertion mid-operation clears everything immediately; no pending push survives.
- Push: on the clk edge where wr_accept=1, wbin <= wbin+1, modulo 2**(ADDR_W+1). wr_addr = wbin[ADDR_W-1:0], which is valid in the same cycle as wr_accept.
- wr_gray_ptr <= wbin_nxt ^ (wbin_nxt >> 1), driven directly from a flop. No combinational logic is permitted on the crossing. It changes by exactly one bit per accepted push.
- Sync: rd_gray_ptr passes through a SYNC_STAGES flop chain giving rq. rq is converted Gray->binary to form rbin.
- full <= (gray(wbin_nxt) == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}). This assumes ADDR_W >= 2.
- level_nxt = wbin_nxt - rbin, taken modulo 2**(ADDR_W+1). wr_level <= level_nxt. almost_full <= (level_nxt >= AFULL_THRESH).
- Push while full: wr_accept=0. Pointer, Gray pointer and level are unchanged. No error is raised unless the optional feature is compiled in.
- Simultaneous push and read advance: both take effect in one update. The level stays unchanged when the read change is visible in rq that cycle.
- Latency: a push updates full/level on the next edge. A read-side pointer change is reflected SYNC_STAGES+1 clk edges after it is stable at rd_gray_ptr.
- Flags are pessimistic. full may stay asserted up to SYNC_STAGES+1 cycles after space exists. full never deasserts early and never permits overflow.
- Wrap-around: the MSB toggles every 2**ADDR_W pushes. full and empty are distinguished only by the MSB and MSB-1 inversion in Gray form.

Optional Feature:
WR_OVERFLOW_STICKY_EN.
- Defined: adds input ovf_clr (1 bit) and output overflow (1 bit, reset 0). overflow <= 1 on any edge with wr_en & full. It is cleared by ovf_clr=1. A set in the same cycle as a clear wins.
- Undefined: neither port exists and pushes while full are silently dropped.
- Core behaviour is identical in both builds.

Test Plan:
1. ADDR_W=4, rd_gray_ptr held 0. After reset, 16 consecutive pushes -> full=1 after the 16th edge; wr_level=16; wr_gray_ptr=5'b11000; wr_addr=0.
2. Same, AFULL_THRESH=12 -> almost_full rises on the edge of the 12th push, with wr_level=12.
3. Full FIFO, then drive rd_gray_ptr=5'b00001 (one read) -> full=0 and wr_level=15 exactly SYNC_STAGES+1=3 edges later, never earlier.
4. Full FIFO, wr_en held for 5 cycles -> wr_accept=0, wr_gray_ptr unchanged; with WR_OVERFLOW_STICKY_EN, overflow=1 until ovf_clr is pulsed.
5. Wrap: 40 pushes with reads tracking 2 cycles behind -> wr_gray_ptr changes exactly one bit per push; wr_addr sequence 0..15,0..15,0..7; full never asserts.
6. Assert rst_n low mid-burst at level 9 -> all outputs 0 asynchronously; the first push after release writes wr_addr=0.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// ============================================================================
// Module   : async_fifo_wr_ctrl
// Purpose  : Write-domain control of the async FIFO: write pointer, Gray export,
//            read-pointer synchronizer and registered full/almost_full/level.
//            Optional sticky overflow flag: define WR_OVERFLOW_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_wr_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ADDR_W - 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_gray_ptr,
`ifdef WR_OVERFLOW_STICKY_EN
    input  logic              ovf_clr,
    output logic              overflow,
`endif
    output logic [ADDR_W:0]   wr_gray_ptr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_accept,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level
);

    localparam logic [ADDR_W:0] C_AFULL = (ADDR_W+1)'(AFULL_THRESH);

    logic [ADDR_W:0]                   wbin_q, wbin_d;
    logic [ADDR_W:0]                   wr_gray_q, wr_gray_d;
    logic [SYNC_STAGES-1:0][ADDR_W:0]  sync_q;
    logic [ADDR_W:0]                   rq;
    logic [ADDR_W:0]                   rbin;
    logic [ADDR_W:0]                   level_d;
    logic                              full_q, full_d;
    logic                              afull_q, afull_d;
    logic [ADDR_W:0]                   level_q;

    assign rq        = sync_q[SYNC_STAGES-1];
    assign wr_accept = wr_en & ~full_q;
    assign wr_addr   = wbin_q[ADDR_W-1:0];

    always_comb begin
        wbin_d    = wbin_q + {{ADDR_W{1'b0}}, wr_accept};
        wr_gray_d = wbin_d ^ (wbin_d >> 1);
        rbin      = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(rq >> i);
        end
        // Full when the write Gray pointer equals the read one with the top two bits inverted.
        full_d  = (wr_gray_d == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
        level_d = wbin_d - rbin;
        afull_d = (level_d >= C_AFULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q    <= '0;
            wr_gray_q <= '0;
            sync_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            level_q   <= '0;
        end else begin
            wbin_q    <= wbin_d;
            wr_gray_q <= wr_gray_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rd_gray_ptr};
            full_q    <= full_d;
            afull_q   <= afull_d;
            level_q   <= level_d;
        end
    end

    assign wr_gray_ptr = wr_gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;

`ifdef WR_OVERFLOW_STICKY_EN
    logic ovf_q, ovf_d;

    // A push rejected while full outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
// ============================================================================
// Module   : tb_async_fifo_wr_ctrl
// Purpose  : Scoreboard bench for async_fifo_wr_ctrl (ADDR_W=4, SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_fifo_wr_ctrl;

    localparam int AW = 4;
    localparam int SS = 2;
    localparam int AT = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW:0]   rd_gray_ptr;
    logic [AW:0]   wr_gray_ptr;
    logic [AW-1:0] wr_addr;
    logic          wr_accept;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_level;
`ifdef WR_OVERFLOW_STICKY_EN
    logic          ovf_clr;
    logic          overflow;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [AW:0] m_wbin;
    logic [AW:0] exp_q[$];

    always #5 clk = ~clk;

    async_fifo_wr_ctrl #(
        .ADDR_W      (AW),
        .SYNC_STAGES (SS),
        .AFULL_THRESH(AT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_gray_ptr(rd_gray_ptr),
`ifdef WR_OVERFLOW_STICKY_EN
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
`endif
        .wr_gray_ptr(wr_gray_ptr),
        .wr_addr    (wr_addr),
        .wr_accept  (wr_accept),
        .full       (full),
        .almost_full(almost_full),
        .wr_level   (wr_level)
    );

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        wr_en       = 1'b0;
        rd_gray_ptr = '0;
`ifdef WR_OVERFLOW_STICKY_EN
        ovf_clr     = 1'b0;
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_wbin = '0;
        exp_q.delete();
    endtask

    // One push attempt: accept and address checked before the edge, the Gray pointer
    // queued for that push is popped and compared after the edge.
    task automatic cycle_push(input logic exp_acc);
        logic [AW:0] exp_g;
        wr_en = 1'b1;
        #1;
        checks++;
        if (wr_accept !== exp_acc) begin
            errors++;
            $display("FAIL accept: got %b want %b", wr_accept, exp_acc);
        end
        if (exp_acc) begin
            checks++;
            if (wr_addr !== m_wbin[AW-1:0]) begin
                errors++;
                $display("FAIL wr_addr: got %0d want %0d", wr_addr, m_wbin[AW-1:0]);
            end
            m_wbin = m_wbin + 1'b1;
            exp_q.push_back(gray(m_wbin));
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (exp_q.size() != 0) exp_g = exp_q.pop_front();
        else exp_g = gray(m_wbin);
        checks++;
        if (wr_gray_ptr !== exp_g) begin
            errors++;
            $display("FAIL wr_gray_ptr: got %b want %b", wr_gray_ptr, exp_g);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b1;
        wr_en       = 1'b0;
        rd_gray_ptr = '0;
`ifdef WR_OVERFLOW_STICKY_EN
        ovf_clr     = 1'b0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_gray_ptr, wr_addr, wr_accept, full, almost_full, wr_level} !== '0) begin
            errors++;
            $display("FAIL reset_async: got gray=%b addr=%0d acc=%b full=%b af=%b lvl=%0d want all 0",
                     wr_gray_ptr, wr_addr, wr_accept, full, almost_full, wr_level);
        end
`ifdef WR_OVERFLOW_STICKY_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b want 0", overflow);
        end
`endif
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_wbin = '0;
        exp_q.delete();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            cycle_push(1'b1);
            checks++;
            if (wr_level !== 5'(k) || almost_full !== (k >= AT) || full !== (k == 16)) begin
                errors++;
                $display("FAIL fill_%0d: got lvl=%0d af=%b full=%b want lvl=%0d af=%b full=%b",
                         k, wr_level, almost_full, full, k, (k >= AT), (k == 16));
            end
        end
        checks++;
        if (wr_addr !== 4'd0 || wr_gray_ptr !== 5'b11000) begin
            errors++;
            $display("FAIL fill_ptr: got addr=%0d gray=%b want addr=0 gray=11000", wr_addr, wr_gray_ptr);
        end
    endtask

    task automatic test_read_latency();
        logic       exp_full;
        logic [AW:0] exp_lvl;
        wr_en       = 1'b0;
        rd_gray_ptr = 5'b00001;
        for (int e = 1; e <= SS + 1; e++) begin
            @(posedge clk); #1;
            exp_full = (e < SS + 1);
            exp_lvl  = (e < SS + 1) ? 5'd16 : 5'd15;
            checks++;
            if (full !== exp_full || wr_level !== exp_lvl) begin
                errors++;
                $display("FAIL read_latency_edge%0d: got full=%b lvl=%0d want full=%b lvl=%0d",
                         e, full, wr_level, exp_full, exp_lvl);
            end
        end
    endtask

    task automatic test_overflow();
        cycle_push(1'b1);
        checks++;
        if (full !== 1'b1 || wr_level !== 5'd16) begin
            errors++;
            $display("FAIL refill: got full=%b lvl=%0d want full=1 lvl=16", full, wr_level);
        end
`ifdef WR_OVERFLOW_STICKY_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: got %b want 0", overflow);
        end
`endif
        for (int i = 0; i < 5; i++) cycle_push(1'b0);
        checks++;
        if (full !== 1'b1 || wr_level !== 5'd16) begin
            errors++;
            $display("FAIL blocked_push: got full=%b lvl=%0d want full=1 lvl=16", full, wr_level);
        end
`ifdef WR_OVERFLOW_STICKY_EN
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b want 1", overflow);
        end
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [AW:0] hist[$];
        do_reset();
        for (int n = 0; n < 40; n++) begin
            hist.push_back(m_wbin);
            if (hist.size() >= 3) rd_gray_ptr = gray(hist[hist.size()-3]);
            cycle_push(1'b1);
            checks++;
            if (full !== 1'b0 || $countones(wr_gray_ptr ^ gray(m_wbin - 1'b1)) != 1) begin
                errors++;
                $display("FAIL wrap_%0d: got full=%b gray=%b want full=0 one-bit step from %b",
                         n, full, wr_gray_ptr, gray(m_wbin - 1'b1));
            end
        end
        rd_gray_ptr = gray(m_wbin);
        repeat (SS + 2) begin @(posedge clk); #1; end
        checks++;
        if (wr_level !== 5'd0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: got lvl=%0d af=%b want lvl=0 af=0", wr_level, almost_full);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int k = 0; k < 9; k++) cycle_push(1'b1);
        checks++;
        if (wr_level !== 5'd9) begin
            errors++;
            $display("FAIL mid_level: got %0d want 9", wr_level);
        end
        wr_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_gray_ptr, wr_addr, full, almost_full, wr_level} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got gray=%b addr=%0d full=%b af=%b lvl=%0d want all 0",
                     wr_gray_ptr, wr_addr, full, almost_full, wr_level);
        end
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_wbin = '0;
        exp_q.delete();
        cycle_push(1'b1);
        checks++;
        if (wr_level !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_level: got %0d want 1", wr_level);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_latency();
        test_overflow();
        test_wrap();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
